// File: rtl/viterbi_pkg.sv
// Shared constants and helpers for the K=3, rate-1/2 convolutional codec:
// generator taps, trellis size, expected-symbol and Hamming-distance functions.
package viterbi_pkg;

  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G0 = 3'b101;
  localparam int NUM_STATES = 4;

  // state = {s1, s0}: s0 is the most recent prior input, s1 the one before it.
  function automatic logic [1:0] expected_symbol(input logic [1:0] state, input logic d);
    logic [2:0] taps;
    taps = {d, state[0], state[1]};
    return {^(taps & G1), ^(taps & G0)};
  endfunction

  function automatic logic [1:0] hamming_dist(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/viterbi_codec_acs_unit.sv
// Add-compare-select for one trellis state: picks the smaller candidate
// (ties to the p=0 predecessor) and extends the winning survivor.
module viterbi_codec_acs_unit #(
  parameter int PM_W     = 6,
  parameter int TB_DEPTH = 16
) (
  input  logic [PM_W-1:0]     cand0_i,
  input  logic [PM_W-1:0]     cand1_i,
  input  logic [TB_DEPTH-2:0] surv0_i,
  input  logic [TB_DEPTH-2:0] surv1_i,
  input  logic                new_bit_i,
  output logic [PM_W-1:0]     pm_o,
  output logic [TB_DEPTH-1:0] surv_o,
  output logic                decision_o
);

  // Survivors arrive pre-truncated: the oldest bit falls off on the shift.
  always_comb begin
    decision_o = (cand1_i < cand0_i);
    pm_o       = cand0_i;
    surv_o     = {surv0_i, new_bit_i};
    if (decision_o) begin
      pm_o   = cand1_i;
      surv_o = {surv1_i, new_bit_i};
    end else begin
      pm_o   = cand0_i;
      surv_o = {surv0_i, new_bit_i};
    end
  end

endmodule

// File: rtl/viterbi_codec_decoder.sv
// Hard-decision Viterbi decoder, 4-state trellis, register-exchange survivors
// of depth TB_DEPTH with per-step metric renormalisation.
module viterbi_codec_decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] sym_i,
  output logic       d_o
);

  logic [PM_W-1:0]     pm_q     [NUM_STATES];
  logic [PM_W-1:0]     pm_d     [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_q   [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_d   [NUM_STATES];
  logic [PM_W-1:0]     acs_pm   [NUM_STATES];
  logic [TB_DEPTH-1:0] acs_surv [NUM_STATES];
  logic [NUM_STATES-1:0] decision_unused;
  logic [1:0]          best_s;
  logic [PM_W-1:0]     min_pm_s;
  logic                d_q, d_d;

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
  endfunction

  // State {a,b} is reached from {0,a} and {1,a} with input bit b.
  for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
    localparam int A = g / 2;
    localparam int B = g % 2;
    logic [PM_W-1:0] cand0_s, cand1_s;

    assign cand0_s = sat_add(pm_q[A],     hamming_dist(sym_i, expected_symbol(2'(A),     1'(B))));
    assign cand1_s = sat_add(pm_q[2 + A], hamming_dist(sym_i, expected_symbol(2'(2 + A), 1'(B))));

    viterbi_codec_acs_unit #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH)) u_acs (
      .cand0_i    (cand0_s),
      .cand1_i    (cand1_s),
      .surv0_i    (surv_q[A][TB_DEPTH-2:0]),
      .surv1_i    (surv_q[2 + A][TB_DEPTH-2:0]),
      .new_bit_i  (1'(B)),
      .pm_o       (acs_pm[g]),
      .surv_o     (acs_surv[g]),
      .decision_o (decision_unused[g])
    );
  end

  // Best pre-update state (lowest index on ties) and minimum new metric.
  always_comb begin
    best_s   = 2'd0;
    min_pm_s = acs_pm[0];
    for (int n = 1; n < NUM_STATES; n++) begin
      if (pm_q[n] < pm_q[best_s]) begin
        best_s = 2'(n);
      end else begin
        best_s = best_s;
      end
      if (acs_pm[n] < min_pm_s) begin
        min_pm_s = acs_pm[n];
      end else begin
        min_pm_s = min_pm_s;
      end
    end
  end

  // Commit one trellis step only on accepted symbols.
  always_comb begin
    pm_d   = pm_q;
    surv_d = surv_q;
    d_d    = d_q;
    if (en_i) begin
      for (int n = 0; n < NUM_STATES; n++) begin
        pm_d[n]   = acs_pm[n] - min_pm_s;
        surv_d[n] = acs_surv[n];
      end
      d_d = surv_q[best_s][TB_DEPTH-1];
    end else begin
      d_d = d_q;
    end
  end

  // Decoder registers; state 0 starts favoured as the known encoder start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_STATES; n++) begin
        pm_q[n]   <= (n == 0) ? {PM_W{1'b0}} : PM_W'(32'd8);
        surv_q[n] <= {TB_DEPTH{1'b0}};
      end
      d_q <= 1'b0;
    end else begin
      pm_q   <= pm_d;
      surv_q <= surv_d;
      d_q    <= d_d;
    end
  end

  assign d_o = d_q;

endmodule

// File: rtl/viterbi_codec_encoder.sv
// Rate-1/2 K=3 convolutional encoder; one registered symbol per enabled cycle.
module viterbi_codec_encoder
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic       d_i,
  output logic       valid_o,
  output logic [1:0] sym_o
);

  logic [1:0] state_q, state_d;
  logic [1:0] sym_q, sym_d;
  logic       valid_q, valid_d;

  // Next symbol and shift-register state; symbol and state hold when idle.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    valid_d = 1'b0;
    if (enable_i) begin
      sym_d   = expected_symbol(state_q, d_i);
      state_d = {state_q[0], d_i};
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Encoder registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 2'b00;
      sym_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign sym_o   = sym_q;

endmodule

// File: rtl/viterbi_codec.sv
// Top level: independent convolutional encoder and Viterbi decoder sharing
// only clock and asynchronous active-low reset.
module viterbi_codec
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable_i,
  input  logic [1:0] dec_d_in,
  output logic       dec_d_out
);

  viterbi_codec_encoder u_enc (
    .clk      (clk),
    .rst_n    (rst),
    .enable_i (enc_enable_i),
    .d_i      (enc_d_in),
    .valid_o  (enc_valid_o),
    .sym_o    (enc_d_out)
  );

  viterbi_codec_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) u_dec (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (dec_enable_i),
    .sym_i (dec_d_in),
    .d_o   (dec_d_out)
  );

endmodule

// File: tb/tb_viterbi_codec.sv
// Scoreboard bench for viterbi_codec: encoder checked against generator
// equations, decoder checked against the source bits delayed by D symbols.
module tb_viterbi_codec;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_en = 1'b0;
  logic       enc_d = 1'b0;
  logic       dec_en = 1'b0;
  logic [1:0] dec_in = 2'b00;
  logic       enc_valid;
  logic [1:0] enc_out;
  logic       dec_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] enc_q[$];
  logic       dec_q[$];
  bit         bits[2000];

  always #5 clk = ~clk;

  viterbi_codec #(.TB_DEPTH(D), .PM_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_en),
    .enc_d_in     (enc_d),
    .enc_valid_o  (enc_valid),
    .enc_d_out    (enc_out),
    .dec_enable_i (dec_en),
    .dec_d_in     (dec_in),
    .dec_d_out    (dec_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: symbol i from bits i, i-1, i-2 (zeros before stream start).
  function automatic logic [1:0] model_sym(input int i);
    bit b0, b1, b2;
    b0 = bits[i];
    b1 = (i >= 1) ? bits[i-1] : 1'b0;
    b2 = (i >= 2) ? bits[i-2] : 1'b0;
    return {b0 ^ b1 ^ b2, b0 ^ b2};
  endfunction

  // Encoder monitor
  logic       em_en;
  logic [1:0] em_exp;
  always begin
    @(posedge clk);
    em_en = enc_en;
    #1;
    if (rst) begin
      if (em_en) begin
        if (enc_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL enc_underflow: got output with no expected symbol at %0t", $time);
        end else begin
          em_exp = enc_q.pop_front();
          check("enc_valid", 32'(enc_valid), 32'd1);
          check("enc_sym", 32'(enc_out), 32'(em_exp));
        end
      end else begin
        check("enc_valid_idle", 32'(enc_valid), 32'd0);
      end
    end
  end

  // Decoder monitor
  logic dm_en;
  logic dm_exp;
  always begin
    @(posedge clk);
    dm_en = dec_en;
    #1;
    if (rst && dm_en) begin
      if (dec_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dec_underflow: got output with no expected bit at %0t", $time);
      end else begin
        dm_exp = dec_q.pop_front();
        check("dec_bit", 32'(dec_out), 32'(dm_exp));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    enc_en = 1'b0;
    dec_en = 1'b0;
    rst    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Feed bits[0..n-1] to the encoder and its registered output to the decoder.
  task automatic run_stream(input int n, input bit flips, input bit gaps, input int abort_at);
    logic [1:0] sym;
    int k;
    do_reset();
    for (int i = 0; i <= n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 5)) begin
          @(negedge clk);
          enc_en = 1'b0;
          dec_en = 1'b0;
        end
      end
      @(negedge clk);
      if (i == abort_at) begin
        enc_en = 1'b0;
        dec_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_enc_sym", 32'(enc_out), 32'd0);
        check("rst_enc_valid", 32'(enc_valid), 32'd0);
        check("rst_dec_bit", 32'(dec_out), 32'd0);
        enc_q.delete();
        dec_q.delete();
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (i < n) begin
        enc_en = 1'b1;
        enc_d  = bits[i];
        enc_q.push_back(model_sym(i));
      end else begin
        enc_en = 1'b0;
      end
      if (i > 0) begin
        k   = i - 1;
        sym = enc_out;
        if (flips && k < 256 && (k % 16) < 2) sym[1] = ~sym[1];
        dec_in = sym;
        dec_en = 1'b1;
        dec_q.push_back((k < D) ? 1'b0 : bits[k - D]);
      end else begin
        dec_en = 1'b0;
      end
    end
    @(negedge clk);
    enc_en = 1'b0;
    dec_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_enc_sym", 32'(enc_out), 32'd0);
    check("reset_enc_valid", 32'(enc_valid), 32'd0);
    check("reset_dec_bit", 32'(dec_out), 32'd0);

    for (int i = 0; i < 20; i++) bits[i] = 1'b0;
    run_stream(20, 1'b0, 1'b0, -1);

    for (int i = 0; i < 24; i++) bits[i] = (i == 0);
    run_stream(24, 1'b0, 1'b0, -1);

    for (int i = 0; i < 1000; i++) bits[i] = 1'($urandom);
    run_stream(1000, 1'b0, 1'b0, -1);
    run_stream(1000, 1'b0, 1'b1, -1);

    for (int i = 0; i < 300; i++) bits[i] = 1'($urandom);
    run_stream(300, 1'b1, 1'b0, -1);

    for (int i = 0; i < 200; i++) bits[i] = 1'($urandom);
    run_stream(200, 1'b0, 1'b0, 120);
    run_stream(200, 1'b0, 1'b0, -1);

    repeat (3) @(negedge clk);
    check("enc_queue_drained", 32'(enc_q.size()), 32'd0);
    check("dec_queue_drained", 32'(dec_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
